// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a one-cycle load handshake and shifts it out
// LSB-first on sout, one bit per clock. The line idles low between frames.
// Optional even-parity bit after the data bits, enabled by defining the
// macro SERIAL_WORD_TX_PARITY_EN. The default build has no parity logic.
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             done
);

  // The counter must reach WIDTH-1 without wrapping.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] shreg_shift;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             done_reg, done_next;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  // Shift register moved one place toward the LSB, zero filled at the top.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shreg_shift[gi] = shreg_reg[gi+1];
    end
  endgenerate
  assign shreg_shift[WIDTH-1] = 1'b0;

  // State and datapath registers; reset abandons any frame immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      sout_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_next;
      sout_reg   <= sout_next;
      done_reg   <= done_next;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Next-state and next-output logic; sout is computed one cycle ahead so
  // the pin itself comes straight from a flop.
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    cnt_next    = cnt_reg;
    sout_next   = sout_reg;
    done_next   = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        sout_next = 1'b0;
        if (load) begin
          shreg_next  = din;
          sout_next   = din[0];
          cnt_next    = '0;
          state_next  = SHIFT;
`ifdef SERIAL_WORD_TX_PARITY_EN
          // Parity of the captured word, so later din changes cannot leak in.
          parity_next = ^din;
`endif
        end
      end
      SHIFT: begin
        if (cnt_reg == LAST) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
          sout_next  = parity_reg;
          state_next = PARITY;
`else
          sout_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
`endif
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          shreg_next = shreg_shift;
          sout_next  = shreg_reg[1];
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: begin
        sout_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
`endif
      default: begin
        sout_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg != IDLE);
  assign sout  = sout_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed self-checking bench for serial_word_tx (WIDTH=8).
// Parity-specific expectations are enabled with SERIAL_WORD_TX_PARITY_EN.
module tb_serial_word_tx;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] din;
  logic       ready;
  logic       busy;
  logic       sout;
  logic       done;

  int checks = 0;
  int errors = 0;

  serial_word_tx #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .ready (ready),
    .busy  (busy),
    .sout  (sout),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; exp_bits is the hand-written expected bit sequence
  // (bit i appears on sout in cycle i). glitch_at >= 0 pulses load with
  // din=FF during that bit cycle. Returns the longest run of ones seen.
  task automatic run_frame(input logic [7:0] word, input logic [7:0] exp_bits,
                           input logic exp_par, input int glitch_at,
                           output int max_run);
    int run;
    run = 0;
    max_run = 0;
    load = 1'b1;
    din  = word;
    tick();
    load = 1'b0;
    din  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bit%0d", i), 32'(sout), 32'(exp_bits[i]));
      check($sformatf("busy%0d", i), 32'({busy, ready, done}), 32'(3'b100));
      if (sout) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      load = (i == glitch_at);
      din  = (i == glitch_at) ? 8'hFF : 8'h00;
      tick();
      load = 1'b0;
      din  = 8'h00;
    end
`ifdef SERIAL_WORD_TX_PARITY_EN
    check("parity", 32'(sout), 32'(exp_par));
    check("par_busy", 32'({busy, ready, done}), 32'(3'b100));
    tick();
`else
    if (exp_par) begin end
`endif
    check("done_cyc", 32'({sout, busy, ready, done}), 32'(4'b0011));
    tick();
    check("after_done", 32'({sout, busy, ready, done}), 32'(4'b0010));
    $display("frame din=%02h max_run=%0d", word, max_run);
  endtask

  initial begin
    int r;
    reset = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'({sout, busy, ready, done}), 32'(4'b0010));
    #3 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle%0d", i), 32'({sout, busy, ready, done}), 32'(4'b0010));
    end

    // 8'hB5 -> 1,0,1,0,1,1,0,1 ; five ones -> parity 1
    run_frame(8'hB5, 8'b1011_0101, 1'b1, -1, r);
    // 8'h0E -> 0,1,1,1,0,0,0,0 ; exactly one run of three ones
    run_frame(8'h0E, 8'b0000_1110, 1'b1, -1, r);
    check("run111", 32'(r), 32'd3);
    // load pulse with FF during bit 3 must be ignored
    run_frame(8'hB5, 8'b1011_0101, 1'b1, 3, r);
    run_frame(8'h07, 8'b0000_0111, 1'b1, -1, r);
    run_frame(8'h03, 8'b0000_0011, 1'b0, -1, r);

    // Back-to-back: load held high, 8'h01 then 8'h80.
    load = 1'b1;
    din  = 8'h01;
    tick();
    din  = 8'h80;
    check("b2b_a0", 32'(sout), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("b2b_a%0d", i), 32'(sout), 32'd0);
    end
    tick();
`ifdef SERIAL_WORD_TX_PARITY_EN
    check("b2b_apar", 32'(sout), 32'd1);
    tick();
`endif
    check("b2b_gap", 32'({sout, busy, ready, done}), 32'(4'b0011));
    tick();
    load = 1'b0;
    check("b2b_b0", 32'({sout, busy, done}), 32'(3'b010));
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("b2b_b%0d", i), 32'(sout), (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
`ifdef SERIAL_WORD_TX_PARITY_EN
    check("b2b_bpar", 32'(sout), 32'd1);
    tick();
`endif
    check("b2b_done", 32'({sout, busy, ready, done}), 32'(4'b0011));
    $display("frame back-to-back 01/80 done");

    // Reset after bit 2 of a frame: outputs clear without a clock edge.
    load = 1'b1;
    din  = 8'hFF;
    tick();
    load = 1'b0;
    tick();
    tick();
    check("pre_rst_bit2", 32'({sout, busy}), 32'(2'b11));
    #2 reset = 1'b0;
    #1;
    check("async_rst", 32'({sout, busy, ready, done}), 32'(4'b0010));
    tick();
    tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("post_rst%0d", i), 32'({sout, busy, ready, done}), 32'(4'b0010));
    end
    $display("frame reset mid-frame done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
